// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access; DM wins conflicts unless IF is starved.
// Latency: req sampled at edge t -> mem_req_o from t+1; ack_o pulses in the RESP cycle after mem_ack_i (min 2 cycles).
module imem_dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [3:0]       LP_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LP_CNT_MAX      = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_served_dm;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic [3:0]          r_starve_cnt;
    logic [CNT_W-1:0]    r_conflict_cnt;
    logic                w_grant_dm;
    logic                w_grant_if;
    logic                w_conflict;
    logic                w_if_starved;

    assign w_conflict   = (r_state == IDLE) && if_req_i && dm_req_i;
    assign w_if_starved = (r_starve_cnt == LP_STARVE_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_dm  = 1'b0;
        w_grant_if  = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req_i && !(if_req_i && w_if_starved)) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = SERVE_DM;
                end else if (if_req_i) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = SERVE_IF;
                end
            end
            SERVE_IF, SERVE_DM: begin
                if (mem_ack_i) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // Requests are deliberately not sampled here so a held req is not served twice.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_served_dm    <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_if_rdata     <= '0;
            r_dm_rdata     <= '0;
            r_starve_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_dm) begin
                r_served_dm <= 1'b1;
                r_mem_we    <= dm_we_i;
                r_mem_addr  <= dm_addr_i;
                r_mem_wdata <= dm_wdata_i;
            end else if (w_grant_if) begin
                r_served_dm <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr_i;
                r_mem_wdata <= '0;
            end

            // Counts DM wins over a waiting fetch; any IF grant or an idle cycle resets it.
            if (w_grant_if || (r_state == IDLE && !if_req_i && !dm_req_i)) begin
                r_starve_cnt <= '0;
            end else if (w_grant_dm && if_req_i && !w_if_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if (w_conflict && r_conflict_cnt != LP_CNT_MAX) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end

            if (r_state == SERVE_IF && mem_ack_i) begin
                r_if_rdata <= mem_rdata_i;
            end
            if (r_state == SERVE_DM && mem_ack_i && !r_mem_we) begin
                r_dm_rdata <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o      = (r_state == SERVE_IF) || (r_state == SERVE_DM);
    assign if_ack_o       = (r_state == RESP) && !r_served_dm;
    assign dm_ack_o       = (r_state == RESP) && r_served_dm;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign if_rdata_o     = r_if_rdata;
    assign dm_rdata_o     = r_dm_rdata;
    assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: transaction model checked every cycle plus directed literal scenarios.
module tb_imem_dmem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LIMIT   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic [CNT_W-1:0]  conflict_cnt_o;

    imem_dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backend: acks after be_wait stall cycles; read data is a fixed word or the inverted address.
    bit          be_en = 1;
    bit          be_fixed = 0;
    bit          be_stray = 0;
    int          be_wait = 0;
    int          be_cnt = 0;
    logic [31:0] be_data = '0;

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    end

    always @(negedge clk_i) begin
        mem_ack_i = 1'b0;
        if (be_stray) begin
            mem_ack_i = 1'b1;
        end else if (mem_req_o && be_en) begin
            if (be_cnt >= be_wait) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = be_fixed ? be_data : ~mem_addr_o;
                be_cnt      = 0;
            end else begin
                be_cnt++;
            end
        end else begin
            be_cnt = 0;
        end
    end

    // Transaction-level model: which requester holds the port, what it asked for, and what came back.
    int          m_phase = 0;       // 0 free, 1 access outstanding, 2 completion cycle
    bit          m_dm = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_ifr = '0;
    logic [31:0] m_dmr = '0;
    int          m_conf = 0;
    int          m_dm_wins = 0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_phase = 0; m_dm = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_ifr = '0; m_dmr = '0; m_conf = 0; m_dm_wins = 0;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (mem_ack_i) begin
                if (!m_dm) m_ifr = mem_rdata_i;
                else if (!m_we) m_dmr = mem_rdata_i;
                m_phase = 2;
            end
        end else if (if_req_i || dm_req_i) begin
            if (if_req_i && dm_req_i) m_conf = (m_conf < CNT_MAX) ? m_conf + 1 : CNT_MAX;
            if (dm_req_i && !(if_req_i && m_dm_wins == LIMIT)) begin
                if (if_req_i) m_dm_wins = (m_dm_wins < LIMIT) ? m_dm_wins + 1 : LIMIT;
                m_dm = 1; m_we = dm_we_i; m_addr = dm_addr_i; m_wdata = dm_wdata_i;
            end else begin
                m_dm_wins = 0;
                m_dm = 0; m_we = 0; m_addr = if_addr_i; m_wdata = '0;
            end
            m_phase = 1;
        end else begin
            m_dm_wins = 0;
        end
    end

    always @(negedge clk_i) begin
        if (started) begin
            chk("mem_req", mem_req_o, m_phase == 1);
            chk("if_ack", if_ack_o, m_phase == 2 && !m_dm);
            chk("dm_ack", dm_ack_o, m_phase == 2 && m_dm);
            chk("mem_we", mem_we_o, m_we);
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_wdata", mem_wdata_o, m_wdata);
            chk("if_rdata", if_rdata_o, m_ifr);
            chk("dm_rdata", dm_rdata_o, m_dmr);
            chk("conflict_cnt", conflict_cnt_o, m_conf);
            chk("ack_exclusive", if_ack_o && dm_ack_o, 1'b0);
        end
    end

    // Grant log (1 = DM, 0 = IF) and ack pulse counters.
    bit grants[$];
    bit prev_req = 0;
    int n_if_ack = 0;
    int n_dm_ack = 0;
    always @(negedge clk_i) begin
        if (started) begin
            if (mem_req_o && !prev_req) grants.push_back(mem_addr_o == 32'h200);
            if (if_ack_o) n_if_ack++;
            if (dm_ack_o) n_dm_ack++;
        end
        prev_req = mem_req_o;
    end

    task automatic wait_ack(input bit dm, input int max, output int lat, output int serve);
        lat = 0;
        serve = 0;
        while (lat < max) begin
            @(negedge clk_i);
            lat++;
            if (mem_req_o) serve++;
            if (dm ? dm_ack_o : if_ack_o) return;
        end
        lat = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, srv, a0, d0, g0, cyc;
        rst_i = 1; if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = '0; dm_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        started = 1;
        @(negedge clk_i);
        chk("reset_mem_req", mem_req_o, 1'b0);
        chk("reset_conflict", conflict_cnt_o, 0);
        chk("reset_if_rdata", if_rdata_o, 0);

        // IF-only fetch, zero-wait backend.
        be_fixed = 1; be_data = 32'h00A00093; be_wait = 0;
        d0 = n_dm_ack;
        if_addr_i = 32'h10; if_req_i = 1;
        wait_ack(0, 10, lat, srv);
        chk("fetch_latency", lat, 2);
        chk("fetch_rdata", if_rdata_o, 32'h00A00093);
        if_req_i = 0;
        @(negedge clk_i);
        chk("fetch_no_dm_ack", n_dm_ack - d0, 0);
        be_fixed = 0;

        // DM write with 3 wait cycles.
        be_wait = 3;
        d0 = n_dm_ack;
        dm_we_i = 1; dm_addr_i = 32'h8; dm_wdata_i = 32'h12; dm_req_i = 1;
        @(negedge clk_i);
        chk("write_we", mem_we_o, 1'b1);
        chk("write_addr", mem_addr_o, 32'h8);
        chk("write_wdata", mem_wdata_o, 32'h12);
        dm_addr_i = 32'hDEAD; dm_wdata_i = 32'hBEEF;
        wait_ack(1, 20, lat, srv);
        chk("write_serve_cycles", srv + 1, 4);
        chk("write_dm_rdata", dm_rdata_o, 32'h0);
        dm_req_i = 0; dm_we_i = 0;
        repeat (2) @(negedge clk_i);
        chk("write_ack_pulses", n_dm_ack - d0, 1);

        // Fetch request held through its completion cycle.
        be_wait = 1;
        a0 = n_if_ack;
        if_addr_i = 32'h20; if_req_i = 1;
        wait_ack(0, 10, lat, srv);
        chk("held_latency", lat, 3);
        @(negedge clk_i);
        if_req_i = 0;
        repeat (6) @(negedge clk_i);
        chk("held_single_ack", n_if_ack - a0, 1);
        chk("held_rdata", if_rdata_o, 32'hFFFFFFDF);
        chk("held_idle", mem_req_o, 1'b0);

        // Continuous conflict: starvation pattern and counter saturation.
        be_wait = 0;
        g0 = grants.size();
        if_addr_i = 32'h100; dm_addr_i = 32'h200; dm_we_i = 0;
        if_req_i = 1; dm_req_i = 1;
        cyc = 0;
        while (grants.size() < g0 + 5 && cyc < 100) begin @(negedge clk_i); cyc++; end
        chk("conflict_after_5", conflict_cnt_o, 5);
        while (grants.size() < g0 + 20 && cyc < 200) begin @(negedge clk_i); cyc++; end
        chk("conflict_saturated", conflict_cnt_o, 15);
        chk("grant_count", grants.size() - g0 >= 20, 1'b1);
        if (grants.size() >= g0 + 10) begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("grant_order_%0d", i), grants[g0 + i], (i % 5) != 4);
        end
        if_req_i = 0; dm_req_i = 0;
        repeat (8) @(negedge clk_i);

        // Reset during an outstanding DM read, then a stray backend ack.
        be_en = 0;
        d0 = n_dm_ack; a0 = n_if_ack;
        dm_addr_i = 32'h44; dm_we_i = 0; dm_req_i = 1;
        cyc = 0;
        while (!mem_req_o && cyc < 10) begin @(negedge clk_i); cyc++; end
        chk("rst_serving", mem_req_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1; dm_req_i = 0;
        @(negedge clk_i);
        rst_i = 0; be_stray = 1;
        repeat (2) @(negedge clk_i);
        be_stray = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_no_dm_ack", n_dm_ack - d0, 0);
        chk("rst_no_if_ack", n_if_ack - a0, 0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_conflict", conflict_cnt_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);

        // Recovery fetch after reset.
        be_en = 1; be_wait = 0;
        if_addr_i = 32'h4; if_req_i = 1;
        wait_ack(0, 10, lat, srv);
        chk("recover_latency", lat, 2);
        chk("recover_rdata", if_rdata_o, 32'hFFFFFFFB);
        if_req_i = 0;
        repeat (3) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
